// File: rtl/diff_window_stats_if.sv
// diff_window_stats_if
//   Bundles the sample-side handshake and the result bus of diff_window_stats.
//   master : producer/observer side (drives start, in_valid, q_in; reads results)
//   slave  : the statistics block itself
// Signals:
//   start    begin a new window (honoured in IDLE/DONE only)
//   in_valid q_in carries a sample this cycle
//   q_in     signed 4-bit sample
//   busy     collecting samples
//   done     one-cycle pulse, results updated
//   sum_out  signed saturated window sum (SUM_W bits)
//   min_out  signed window minimum
//   max_out  signed window maximum
//   sat_out  sum clamped at least once in the window
//   count    samples accepted in the current window
interface diff_window_stats_if #(
  parameter int SUM_W = 8
);
  logic             start;
  logic             in_valid;
  logic [3:0]       q_in;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] sum_out;
  logic [3:0]       min_out;
  logic [3:0]       max_out;
  logic             sat_out;
  logic [7:0]       count;

  modport master (
    output start, in_valid, q_in,
    input  busy, done, sum_out, min_out, max_out, sat_out, count
  );

  modport slave (
    input  start, in_valid, q_in,
    output busy, done, sum_out, min_out, max_out, sat_out, count
  );
endinterface

// File: rtl/diff_window_stats.sv
// diff_window_stats
//   Collects WIN valid signed 4-bit samples and reports a saturating signed
//   sum, the minimum, the maximum and a saturation flag, with a one-cycle
//   done pulse per completed window.
// Ports:
//   clk   system clock (posedge)
//   reset synchronous active-high reset
//   bus   diff_window_stats_if.slave (start/in_valid/q_in in, results out)
module diff_window_stats #(
  parameter int WIN   = 8,
  parameter int SUM_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  diff_window_stats_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0]              WIN_LAST = 8'(WIN - 1);
  localparam logic signed [SUM_W-1:0] SUM_MAX  = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN  = {1'b1, {(SUM_W-1){1'b0}}};

  state_t                  r_state;
  logic signed [SUM_W-1:0] r_acc;
  logic signed [3:0]       r_min_acc;
  logic signed [3:0]       r_max_acc;
  logic                    r_sat_acc;
  logic                    r_first;
  logic [7:0]              r_count;
  logic                    r_busy;
  logic                    r_done;
  logic signed [SUM_W-1:0] r_sum_out;
  logic signed [3:0]       r_min_out;
  logic signed [3:0]       r_max_out;
  logic                    r_sat_out;

  logic signed [3:0]       w_q;
  logic signed [SUM_W:0]   w_q_ext;
  logic signed [SUM_W:0]   w_acc_wide;
  logic signed [SUM_W-1:0] w_acc_next;
  logic                    w_ovf;
  logic signed [3:0]       w_min_next;
  logic signed [3:0]       w_max_next;
  logic                    w_last;

  assign w_q     = bus.q_in;
  // One guard bit is enough: |q_in| <= 8 and SUM_W >= 4.
  assign w_q_ext = {{(SUM_W-3){w_q[3]}}, w_q};
  assign w_acc_wide = {r_acc[SUM_W-1], r_acc} + w_q_ext;
  assign w_last  = (r_count == WIN_LAST);

  // Per-add saturation: guard bit and sign bit disagree on overflow.
  always_comb begin
    w_acc_next = w_acc_wide[SUM_W-1:0];
    w_ovf      = 1'b0;
    if (w_acc_wide[SUM_W] != w_acc_wide[SUM_W-1]) begin
      w_ovf = 1'b1;
      if (w_acc_wide[SUM_W]) begin
        w_acc_next = SUM_MIN;
      end else begin
        w_acc_next = SUM_MAX;
      end
    end else begin
      w_ovf = 1'b0;
    end
  end

  // Running min/max; the first sample of a window loads both directly.
  always_comb begin
    w_min_next = r_min_acc;
    w_max_next = r_max_acc;
    if (r_first) begin
      w_min_next = w_q;
      w_max_next = w_q;
    end else begin
      w_min_next = (w_q < r_min_acc) ? w_q : r_min_acc;
      w_max_next = (w_q > r_max_acc) ? w_q : r_max_acc;
    end
  end

  // Window FSM with accumulators and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_min_acc <= 4'sd0;
      r_max_acc <= 4'sd0;
      r_sat_acc <= 1'b0;
      r_first   <= 1'b0;
      r_count   <= 8'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum_out <= '0;
      r_min_out <= 4'sd0;
      r_max_out <= 4'sd0;
      r_sat_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          // Samples presented here are dropped; only start matters.
          if (bus.start) begin
            r_acc     <= '0;
            r_count   <= 8'd0;
            r_sat_acc <= 1'b0;
            r_first   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_ACC;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ACC: begin
          if (bus.in_valid) begin
            r_acc     <= w_acc_next;
            r_sat_acc <= r_sat_acc | w_ovf;
            r_min_acc <= w_min_next;
            r_max_acc <= w_max_next;
            r_first   <= 1'b0;
            r_count   <= r_count + 8'd1;
            if (w_last) begin
              // Results include the completing sample.
              r_sum_out <= w_acc_next;
              r_min_out <= w_min_next;
              r_max_out <= w_max_next;
              r_sat_out <= r_sat_acc | w_ovf;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_ACC;
            end
          end else begin
            r_busy  <= 1'b1;
            r_state <= S_ACC;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.sum_out = r_sum_out;
  assign bus.min_out = r_min_out;
  assign bus.max_out = r_max_out;
  assign bus.sat_out = r_sat_out;
  assign bus.count   = r_count;

endmodule

// File: tb/tb_diff_window_stats.sv
// tb_diff_window_stats
//   Three instances: A (WIN=4,SUM_W=8), S (WIN=4,SUM_W=5), B (WIN=2,SUM_W=8).
//   Expected window results are queued when the last sample is driven and
//   popped by a monitor whenever the selected instance pulses done.
module tb_diff_window_stats;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v;
  logic       valid_v;
  logic [3:0] q_v;
  int         sel;

  always #5 clk = ~clk;

  diff_window_stats_if #(.SUM_W(8)) if_a ();
  diff_window_stats_if #(.SUM_W(5)) if_s ();
  diff_window_stats_if #(.SUM_W(8)) if_b ();

  assign if_a.start = (sel == 0) & start_v;
  assign if_a.in_valid = (sel == 0) & valid_v;
  assign if_a.q_in = q_v;
  assign if_s.start = (sel == 1) & start_v;
  assign if_s.in_valid = (sel == 1) & valid_v;
  assign if_s.q_in = q_v;
  assign if_b.start = (sel == 2) & start_v;
  assign if_b.in_valid = (sel == 2) & valid_v;
  assign if_b.q_in = q_v;

  diff_window_stats #(.WIN(4), .SUM_W(8)) dut_a (.clk(clk), .reset(rst), .bus(if_a));
  diff_window_stats #(.WIN(4), .SUM_W(5)) dut_s (.clk(clk), .reset(rst), .bus(if_s));
  diff_window_stats #(.WIN(2), .SUM_W(8)) dut_b (.clk(clk), .reset(rst), .bus(if_b));

  logic       o_busy, o_done, o_sat;
  logic [7:0] o_sum, o_count;
  logic [3:0] o_min, o_max;

  always_comb begin
    o_busy = 1'b0; o_done = 1'b0; o_sat = 1'b0;
    o_sum = 8'd0; o_count = 8'd0; o_min = 4'd0; o_max = 4'd0;
    case (sel)
      0: begin
        o_busy = if_a.busy; o_done = if_a.done; o_sat = if_a.sat_out;
        o_sum = if_a.sum_out; o_count = if_a.count;
        o_min = if_a.min_out; o_max = if_a.max_out;
      end
      1: begin
        o_busy = if_s.busy; o_done = if_s.done; o_sat = if_s.sat_out;
        o_sum = {{3{if_s.sum_out[4]}}, if_s.sum_out}; o_count = if_s.count;
        o_min = if_s.min_out; o_max = if_s.max_out;
      end
      2: begin
        o_busy = if_b.busy; o_done = if_b.done; o_sat = if_b.sat_out;
        o_sum = if_b.sum_out; o_count = if_b.count;
        o_min = if_b.min_out; o_max = if_b.max_out;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  typedef struct {
    logic [7:0] sum;
    logic [3:0] mn;
    logic [3:0] mx;
    logic       sat;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    int         sel;
    int         n;
    logic [15:0] smp;   // sample k in bits [4k+3:4k]
    logic [7:0]  gap;   // idle cycles before sample k in bits [2k+1:2k]
    logic [7:0]  e_sum;
    logic [3:0]  e_min;
    logic [3:0]  e_max;
    logic        e_sat;
  } win_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic st, input logic v, input logic [3:0] q);
    start_v = st;
    valid_v = v;
    q_v = q;
    @(negedge clk);
  endtask

  function automatic logic [7:0] win_of(input int s);
    return (s == 2) ? 8'd2 : 8'd4;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (o_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("done_sum", o_sum, e.sum);
        chk("done_min", o_min, e.mn);
        chk("done_max", o_max, e.mx);
        chk("done_sat", o_sat, e.sat);
        chk("done_count", o_count, e.cnt);
        chk("done_busy", o_busy, 1'b0);
      end
    end
  end

  task automatic run_win(input win_t w);
    exp_t e;
    sel = w.sel;
    cyc(1'b1, 1'b0, 4'($urandom));
    chk("start_busy", o_busy, 1'b1);
    chk("start_count", o_count, 8'd0);
    for (int k = 0; k < w.n; k++) begin
      for (int g = 0; g < int'(w.gap[2*k +: 2]); g++) begin
        cyc(1'b0, 1'b0, 4'($urandom));
        chk("gap_count", o_count, 8'(k));
      end
      if (k == w.n - 1) begin
        e.sum = w.e_sum; e.mn = w.e_min; e.mx = w.e_max;
        e.sat = w.e_sat; e.cnt = win_of(w.sel);
        sb.push_back(e);
      end
      cyc(1'b0, 1'b1, w.smp[4*k +: 4]);
      chk("live_count", o_count, 8'(k + 1));
      chk("live_busy", o_busy, (k < w.n - 1) ? 1'b1 : 1'b0);
    end
    cyc(1'b0, 1'b0, 4'd0);
    chk("post_done", o_done, 1'b0);
    chk("hold_sum", o_sum, w.e_sum);
    chk("hold_minmax", {o_min, o_max}, {w.e_min, w.e_max});
    chk("hold_count", o_count, 8'(w.n));
    chk("hold_busy", o_busy, 1'b0);
    chk("sb_drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t tbl[6];
    exp_t e;
    tbl[0] = '{0, 4, 16'h87E3, 8'h00, 8'h00, 4'h8, 4'h7, 1'b0}; // 3,-2,7,-8
    tbl[1] = '{0, 4, 16'h96F5, 8'h18, 8'h03, 4'h9, 4'h6, 1'b0}; // 5,..,-1,.,6,-7
    tbl[2] = '{1, 4, 16'h8777, 8'h00, 8'h07, 4'h8, 4'h7, 1'b1}; // 7,7,7(clamp 15),-8
    tbl[3] = '{1, 4, 16'h8888, 8'h00, 8'hF0, 4'h8, 4'h8, 1'b1}; // -8 x4 clamp -16
    tbl[4] = '{1, 4, 16'h8866, 8'h00, 8'hFC, 4'h8, 4'h6, 1'b0}; // 6,6,-8,-8 no clamp
    tbl[5] = '{0, 4, 16'hDDDD, 8'h00, 8'hF4, 4'hD, 4'hD, 1'b0}; // -3 x4

    sel = 0; rst = 1'b1; start_v = 1'b0; valid_v = 1'b0; q_v = 4'd0;

    // Reset, then samples without start must be ignored.
    cyc(1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 4'd5);
      chk("idle_outs", {o_busy, o_done, o_sat, o_sum, o_min, o_max, o_count}, 27'd0);
    end

    for (int i = 0; i < 6; i++) run_win(tbl[i]);

    // Back-to-back windows with start during DONE (WIN=2).
    sel = 2;
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd4);
    e = '{8'h08, 4'h4, 4'h4, 1'b0, 8'd2};
    sb.push_back(e);
    cyc(1'b0, 1'b1, 4'd4);
    cyc(1'b1, 1'b1, 4'd7);             // DONE: restart, sample dropped
    chk("b2b_busy", o_busy, 1'b1);
    chk("b2b_count", o_count, 8'd0);
    cyc(1'b0, 1'b1, 4'd6);
    chk("b2b_count1", o_count, 8'd1);
    e = '{8'h07, 4'h1, 4'h6, 1'b0, 8'd2};
    sb.push_back(e);
    cyc(1'b0, 1'b1, 4'd1);
    cyc(1'b0, 1'b0, 4'd0);
    chk("b2b_drain", sb.size(), 0);

    // Reset mid-window aborts it and clears results.
    sel = 0;
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd2);
    cyc(1'b0, 1'b1, 4'd3);
    chk("mid_count", o_count, 8'd2);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    chk("rst_outs", {o_busy, o_done, o_sat, o_sum, o_min, o_max, o_count}, 27'd0);
    cyc(1'b0, 1'b1, 4'd7);
    chk("rst_idle", {o_busy, o_count}, 9'd0);

    // start during ACC is ignored.
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd1);
    cyc(1'b1, 1'b1, 4'd2);
    cyc(1'b1, 1'b0, 4'd0);
    chk("acc_start_count", o_count, 8'd2);
    chk("acc_start_busy", o_busy, 1'b1);
    cyc(1'b0, 1'b1, 4'd3);
    e = '{8'h0A, 4'h1, 4'h4, 1'b0, 8'd4};
    sb.push_back(e);
    cyc(1'b0, 1'b1, 4'd4);
    cyc(1'b0, 1'b0, 4'd0);
    chk("acc_start_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/diff_window_stats.md
Name: diff_window_stats

Overview:
- Downstream consumer of the signed 4-bit difference stage output `q`.
- Collects a window of WIN valid samples and produces four registered results: saturating signed sum, minimum, maximum, and a saturation flag.
- A one-cycle `done` pulse marks each completed window.
- Sits between the subtract datapath and any reporting/checking logic; one clock, no CDC.

Parameters:
- WIN, 8, number of valid samples per window (>=1, <=255).
- SUM_W, 8, width of the signed sum accumulator and sum_out (>=4).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new window (sampled in IDLE/DONE only).
- in_valid  input  1  q_in carries a sample this cycle.
- q_in  input  4  signed sample (two's complement, -8..7).
- busy  output  1  high while collecting (state ACC).
- done  output  1  one-cycle pulse: results updated.
- sum_out  output  SUM_W  signed saturated window sum.
- min_out  output  4  signed window minimum.
- max_out  output  4  signed window maximum.
- sat_out  output  1  sum saturated at least once in the window.
- count  output  8  samples accepted in the current window.

Behaviour:
- Interface: one clock, `clk`; reset is synchronous and active-high, port `reset`, sampled on the posedge of `clk`.
- Reset values: state=IDLE, busy=0, done=0, sum_out=0, min_out=0, max_out=0, sat_out=0, count=0, internal accumulators=0.
- Reset mid-window aborts the window. Result registers are cleared; no done pulse.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - start=1 -> clear the accumulator, count, sat accumulator, and first-flag; go to ACC.
  - in_valid is ignored in IDLE.
- ACC (busy=1), per cycle with in_valid=1:
  - acc_next = acc + sign-extended q_in.
  - If acc_next > 2^(SUM_W-1)-1, clamp to that value and set sat_acc. If acc_next < -2^(SUM_W-1), clamp to that value and set sat_acc.
  - First sample of the window loads min_acc and max_acc directly. Later samples use a signed compare: min_acc=min(min_acc,q_in), max_acc=max(max_acc,q_in).
  - count increments.
- ACC with in_valid=0: hold all accumulators; no timeout.
- start during ACC is ignored.
- Window completion:
  - The completing edge is the one in ACC with in_valid=1 and count==WIN-1.
  - On that edge, load the result registers with the values including that sample: sum_out, min_out, max_out, sat_out.
  - count goes to WIN; state goes to DONE.
- DONE: done=1 for exactly this one cycle and busy=0.
  - Next state is ACC if start=1, else IDLE.
  - Starting from DONE clears the accumulators and count exactly as from IDLE.
  - in_valid during DONE is ignored, so samples presented then are dropped.
- Latency: done and the results are visible in the cycle after the last sample is accepted.
- Result registers hold their values until the next window completes or reset. They do not change during an ACC window in progress.
- count is visible live during ACC. It holds at WIN in DONE/IDLE until the next start clears it to 0.
- WIN=1: the first valid sample in ACC completes the window. sum=q_in, min=max=q_in.
- Saturation is applied per add, not at window end. Later negative samples may pull a clamped sum back into range, but sat_out stays set.

Test Plan:
- Reset then idle: hold reset 2 cycles, release; in_valid=1 with q_in=5 and no start -> all outputs 0, busy=0, done never pulses.
- Basic window, WIN=4:
  - Stimulus: start, then samples 3, -2, 7, -8 on consecutive cycles.
  - Required: done one cycle after -8, with sum_out=0, min_out=-8, max_out=7, sat_out=0, count=4. Next cycle done=0 and the outputs hold.
- Gapped input, WIN=4: samples 5, gap, gap, -1, gap, 6, -7 -> sum_out=3, min_out=-7, max_out=6; done 1 cycle after -7.
- Saturation, SUM_W=5, WIN=4:
  - Samples 7, 7, 7, -8 -> running sums 7, 14, 15(clamped), 7; sum_out=7, sat_out=1.
  - Samples -8, -8, -8, -8 -> sum_out=-16, sat_out=1.
- Back-to-back windows, WIN=2:
  - Stimulus: samples 4, 4, then start asserted during DONE, then 6, 1.
  - Required: first done with sum_out=8. Second window starts immediately, count restarts at 0, second done with sum_out=7, min_out=1, max_out=6.
- Reset mid-window, WIN=4: after 2 samples (2, 3), pulse reset -> state IDLE, count=0, sum_out=0, no done.
- start during ACC is ignored: window completes normally after WIN samples.
